// File: rtl/rtl_cnt_lp_load.sv
`default_nettype none
// ============================================================================
//  Module   : rtl_cnt_lp_load
//  Purpose  : N-bit loadable up-counter with a K-bit fast low segment and a
//             lazily settled upper-segment increment. The upper increment is
//             built by a carry vector that advances one bit per cycle. A load
//             starts a SETTLE window of N-K cycles during which increments
//             are refused.
//  Revision : 1.0  initial release
// ============================================================================
module rtl_cnt_lp_load #(
  parameter int N = 64,
  parameter int K = $clog2(N)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         cin,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic         cin_rdy,
  output logic [N-1:0] counter,
  output logic         cout
);

  localparam int HW = N - K;            // upper (lazy) segment width
  localparam int CW = $clog2(HW + 1);   // settle down-counter width
  localparam logic [CW-1:0] SETTLE_LAST = CW'(HW - 1);

  // Reject parameter sets where the low segment wraps faster than the upper
  // carry vector can settle.
  generate
    if (N < 8 || K < 2 || K >= N || (64'd1 << K) < 64'(N - K + 1)) begin : g_param_check
      $error("rtl_cnt_lp_load: illegal N/K combination");
    end
  endgenerate

  typedef enum logic [0:0] {
    READY  = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   settle_cnt;
  logic [CW-1:0]   settle_cnt_nxt;

  logic [K-1:0]    lo;
  logic [HW-1:0]   hi;
  // lazy_c[j] is the carry into upper bit j+1; the carry into bit 0 is 1.
  logic [HW-1:0]   lazy_c;
  logic [HW:0]     carry;
  logic [HW-1:0]   lazy_c_nxt;
  logic [HW-1:0]   hi_inc;
  logic            hi_cout;
  logic [K:0]      lo_sum;
  logic            lo_wrap;
  logic            accept;

  // Upper-segment increment: each bit is a single XOR against its settled
  // carry, and each carry bit only looks one position down.
  assign carry      = {lazy_c, 1'b1};
  assign lazy_c_nxt = carry[HW-1:0] & hi;
  assign hi_inc     = hi ^ carry[HW-1:0];
  assign hi_cout    = carry[HW];

  // The only carry-propagate adder: K bits plus carry out.
  assign lo_sum  = {1'b0, lo} + {{K{1'b0}}, 1'b1};
  assign lo_wrap = lo_sum[K];

  assign accept  = cin & cin_rdy & ~load;
  assign counter = {hi, lo};

  // State register, settle down-counter and registered ready flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= READY;
      settle_cnt <= '0;
      cin_rdy    <= 1'b1;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      cin_rdy    <= (state_nxt == READY);
    end
  end

  // Next-state logic: a load always (re)opens the settle window.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      READY: begin
        if (load) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = SETTLE_LAST;
        end
      end
      SETTLE: begin
        if (load) begin
          settle_cnt_nxt = SETTLE_LAST;
        end else if (settle_cnt == '0) begin
          state_nxt      = READY;
        end else begin
          settle_cnt_nxt = settle_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt      = READY;
        settle_cnt_nxt = '0;
      end
    endcase
  end

  // Counter datapath. Whenever the upper segment changes, the carry vector is
  // cleared and re-settles over the next HW cycles; the low segment needs at
  // least 2^K accepted increments before it can wrap again, which is enough.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      lo     <= '0;
      hi     <= '0;
      lazy_c <= '0;   // already the settled carry vector for hi == 0
      cout   <= 1'b0;
    end else if (load) begin
      lo     <= load_val[K-1:0];
      hi     <= load_val[N-1:K];
      lazy_c <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      lo <= lo_sum[K-1:0];
      if (lo_wrap) begin
        hi     <= hi_inc;
        lazy_c <= '0;
        cout   <= hi_cout;
      end else begin
        lazy_c <= lazy_c_nxt;
        cout   <= 1'b0;
      end
    end else begin
      lazy_c <= lazy_c_nxt;
      cout   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtl_cnt_lp_load.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtl_cnt_lp_load
//  Purpose  : Directed self-checking bench for rtl_cnt_lp_load at N=64, K=6.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtl_cnt_lp_load;

  localparam int N = 64;
  localparam int K = 6;

  logic         clk;
  logic         nrst;
  logic         cin;
  logic         load;
  logic [N-1:0] load_val;
  logic         cin_rdy;
  logic [N-1:0] counter;
  logic         cout;

  int vectors;
  int miscompares;

  rtl_cnt_lp_load #(.N(N), .K(K)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .cin      (cin),
    .load     (load),
    .load_val (load_val),
    .cin_rdy  (cin_rdy),
    .counter  (counter),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (cin_rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  saw_cout;
    bit  saw_low;
    bit  moved;

    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b0;
    cin         = 1'b0;
    load        = 1'b0;
    load_val    = '0;

    // Reset state
    tick();
    check("rst_counter", counter, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_rdy", {63'd0, cin_rdy}, 64'd1);
    nrst = 1'b1;

    // Sustained cin across the first low-segment wrap: 2^K+3 = 67 increments
    cin      = 1'b1;
    saw_cout = 1'b0;
    saw_low  = 1'b0;
    for (int i = 1; i <= 67; i++) begin
      tick();
      if (cout !== 1'b0) saw_cout = 1'b1;
      if (cin_rdy !== 1'b1) saw_low = 1'b1;
      if (i == 64) check("cnt_at_64", counter, 64'd64);
    end
    check("cnt_67", counter, 64'd67);
    check("cnt_67_no_cout", {63'd0, saw_cout}, 64'd0);
    check("cnt_67_rdy_high", {63'd0, saw_low}, 64'd0);

    // load and cin together in READY: load wins, no increment
    load     = 1'b1;
    load_val = 64'h1234_5678_9ABC_DEF0;
    tick();
    load = 1'b0;
    cin  = 1'b0;
    check("ldcin_counter", counter, 64'h1234_5678_9ABC_DEF0);
    check("ldcin_rdy", {63'd0, cin_rdy}, 64'd0);
    check("ldcin_cout", {63'd0, cout}, 64'd0);

    // Reload 10 cycles into the window: full 58-cycle window from new load
    for (int i = 0; i < 9; i++) tick();
    check("mid_settle_rdy", {63'd0, cin_rdy}, 64'd0);
    load     = 1'b1;
    cin      = 1'b1;
    load_val = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    load = 1'b0;
    check("reload_counter", counter, 64'hFFFF_FFFF_FFFF_FFFD);
    moved = 1'b0;
    n     = 0;
    while (cin_rdy !== 1'b1 && n < 200) begin
      if (counter !== 64'hFFFF_FFFF_FFFF_FFFD || cout !== 1'b0) moved = 1'b1;
      tick();
      n++;
    end
    check("reload_window_len", 64'(n), 64'd58);
    check("reload_frozen", {63'd0, moved}, 64'd0);
    tick();
    check("wrap_fe", counter, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_fe_cout", {63'd0, cout}, 64'd0);
    tick();
    check("wrap_ff", counter, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_ff_cout", {63'd0, cout}, 64'd0);
    tick();
    check("wrap_00", counter, 64'd0);
    check("wrap_00_cout", {63'd0, cout}, 64'd1);
    tick();
    check("wrap_01", counter, 64'd1);
    check("wrap_01_cout", {63'd0, cout}, 64'd0);
    cin = 1'b0;

    // First low wrap right after a load of 0x3F
    load     = 1'b1;
    load_val = 64'h0000_0000_0000_003F;
    tick();
    load = 1'b0;
    wait_ready(n);
    check("ld3f_window_len", 64'(n), 64'd58);
    cin = 1'b1;
    tick();
    cin = 1'b0;
    check("ld3f_inc", counter, 64'h40);
    check("ld3f_cout", {63'd0, cout}, 64'd0);
    tick();
    check("idle_hold", counter, 64'h40);

    // Long upper carry chain, then two more low wraps needing re-settle
    load     = 1'b1;
    load_val = 64'h00FF_FFFF_FFFF_FFFF;
    tick();
    load = 1'b0;
    wait_ready(n);
    check("chain_window_len", 64'(n), 64'd58);
    cin = 1'b1;
    tick();
    check("chain_inc", counter, 64'h0100_0000_0000_0000);
    for (int i = 0; i < 128; i++) tick();
    cin = 1'b0;
    check("chain_plus128", counter, 64'h0100_0000_0000_0080);

    // Second load 10 cycles into SETTLE, reset at cycle 20 of new window
    load     = 1'b1;
    load_val = 64'hAAAA_0000_5555_0000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    load     = 1'b1;
    load_val = 64'h0BAD_F00D_0000_0001;
    tick();
    load = 1'b0;
    saw_low = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (cin_rdy !== 1'b0) saw_low = 1'b0;
      tick();
    end
    check("rst_window_rdy_low", {63'd0, saw_low}, 64'd1);
    nrst     = 1'b0;
    load     = 1'b1;
    cin      = 1'b1;
    load_val = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check("midrst_counter", counter, 64'd0);
    check("midrst_rdy", {63'd0, cin_rdy}, 64'd1);
    check("midrst_cout", {63'd0, cout}, 64'd0);
    nrst = 1'b1;
    load = 1'b0;
    tick();
    cin = 1'b0;
    check("post_rst_inc", counter, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rtl_cnt_lp_load.md
RTL_CNT_LP_LOAD -- requirements
Module: rtl_cnt_lp_load

Interface
REQ-001 Parameter N, default 64: counter width in bits; N >= 8.
REQ-002 Parameter K, default $clog2(N): low-segment width; elaboration SHALL fail unless 2^K >= N-K+1 and 2 <= K < N.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 cin  input  1  increment request; counted only when cin_rdy=1.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 load_val  input  N  value written on load.
REQ-008 cin_rdy  output  1  registered; 1 = increments are accepted this cycle.
REQ-009 counter  output  N  registered count value.
REQ-010 cout  output  1  registered carry-out pulse, one cycle wide.

Function
REQ-011 Accepted increment = cin & cin_rdy & ~load; the counter SHALL equal previous value +1 mod 2^N on the next edge.
REQ-012 Latency: counter and cout SHALL reflect an accepted increment exactly one cycle after acceptance.
REQ-013 cout SHALL be 1 only in the cycle after an accepted increment with counter = all-ones (counter becomes 0); otherwise 0.
REQ-014 Non-accepted cycles SHALL hold counter and drive cout=0.
REQ-015 load=1 SHALL set counter=load_val and cout=0 on the next edge, overriding cin regardless of cin_rdy.
REQ-016 Load SHALL drive cin_rdy=0 for exactly N-K cycles beginning the cycle after the load edge, then 1.
REQ-017 A load while cin_rdy=0 SHALL restart the N-K cycle window from the new load.
REQ-018 While cin_rdy=0, cin SHALL be ignored (no count change, cout=0).
REQ-019 Timing: the only carry-propagate adder SHALL be K bits wide; the upper N-K bits SHALL be updated from a precomputed (lazy) incremented copy settled one bit per cycle, with no combinational path depending on N beyond a 2:1 mux per bit.
REQ-020 The lazy upper-segment copy SHALL equal counter[N-1:K]+1 (with carry into bit N) whenever cin_rdy=1 and the low segment is all-ones.
REQ-021 Two states: READY (cin_rdy=1) and SETTLE (down-counter of N-K cycles); READY->SETTLE on load; SETTLE->READY when the count expires; SETTLE->SETTLE (reloaded) on load.
REQ-022 Sustained cin=1 in READY SHALL be accepted every cycle, indefinitely, including across low-segment and full-width wrap-around.

Reset
REQ-023 nrst=0 on an edge SHALL set counter=0, cout=0, cin_rdy=1, and the lazy copy to its settled value for counter=0; it overrides load and cin.
REQ-024 Reset asserted mid-SETTLE SHALL abort the window; cin_rdy=1 in the first cycle after release.
REQ-025 No output SHALL be X after the first reset edge.

Verification
REQ-026 Reset, then cin=1 for 2^K+3 cycles (N=64,K=6) -> counter=67 on the final edge, cout never 1, cin_rdy constantly 1.
REQ-027 load_val=0xFFFF_FFFF_FFFF_FFFD, cin=1 held -> cin_rdy=0 for 58 cycles, counter frozen; then counter FE, FF, 0 on successive edges; cout=1 only in the cycle counter reads 0.
REQ-028 load_val=0x0000_0000_0000_003F, wait out SETTLE, one cin -> counter=0x40 (upper carry correct on first wrap after load).
REQ-029 load and cin both 1 in READY -> counter=load_val next cycle, no increment, cin_rdy falls.
REQ-030 Second load 10 cycles into SETTLE, then nrst=0 at cycle 20 of the new window -> cin_rdy=0 until reset, then counter=0, cin_rdy=1, cout=0.
REQ-031 Random cin/load/nrst for 10^6 cycles at N=16,K=4 and N=64,K=6 against a reference model: counter, cout, cin_rdy match every cycle.
